// File: rtl/instr_encoder.sv
// Packs decoded RV32 fields into instruction words, tags each with a sequential address
// and streams them through a small FIFO. Optional INSTR_ENCODER_STATS_EN adds enc_count.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [11:0] in_immed,
  input  logic [9:0]  in_func,
  input  logic [19:0] in_joffset,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
`ifdef INSTR_ENCODER_STATS_EN
  output logic [15:0] enc_count,
`endif
  output logic        err_illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  function automatic logic [31:0] encode_word(
    input logic [2:0]  kind,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [11:0] immed,
    input logic [9:0]  func,
    input logic [19:0] joffset
  );
    logic [31:0] word;
    case (kind)
      3'd0:    word = {func[9:3], rs2, rs1, func[2:0], rd, 7'b0110011};
      3'd1:    word = {immed, rs1, func[2:0], rd, 7'b0010011};
      3'd2:    word = {immed[11:5], rs2, rs1, func[2:0], immed[4:0], 7'b0100011};
      3'd3:    word = {immed[11], immed[9:4], rs2, rs1, func[2:0], immed[3:0], immed[10], 7'b1100011};
      3'd4:    word = {joffset[19], joffset[9:0], joffset[10], joffset[18:11], rd, 7'b1101111};
      3'd5:    word = {immed, rs1, func[2:0], rd, 7'b0000011};
      3'd6:    word = {joffset, rd, 7'b0010111};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  logic [31:0]   mem_instr_r [DEPTH];
  logic [31:0]   mem_addr_r  [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   addr_r;

  logic          full_s;
  logic          empty_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   word_s;
  logic [AW-1:0] rd_ptr_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic [31:0]   head_instr_nxt_s;
  logic [31:0]   head_addr_nxt_s;

  assign full_s   = (count_r == CW'(DEPTH));
  assign empty_s  = (count_r == CW'(0));
  assign in_ready = !full_s && !flush;
  assign accept_s = in_valid && in_ready;
  assign push_s   = accept_s && (in_kind != 3'd7);
  assign pop_s    = !empty_s && out_ready;
  assign word_s   = encode_word(in_kind, in_rd, in_rs1, in_rs2, in_immed, in_func, in_joffset);

  // Next head of the queue so the output registers always show the oldest word.
  always_comb begin
    rd_ptr_nxt_s     = rd_ptr_r;
    count_nxt_s      = count_r;
    head_instr_nxt_s = 32'h0000_0000;
    head_addr_nxt_s  = 32'h0000_0000;
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    // A word written this cycle lands exactly at the new head only when the queue drains to it.
    if (count_nxt_s == CW'(0)) begin
      head_instr_nxt_s = 32'h0000_0000;
      head_addr_nxt_s  = 32'h0000_0000;
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_instr_nxt_s = word_s;
      head_addr_nxt_s  = addr_r;
    end else begin
      head_instr_nxt_s = mem_instr_r[rd_ptr_nxt_s];
      head_addr_nxt_s  = mem_addr_r[rd_ptr_nxt_s];
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_instr_r[wr_ptr_r] <= word_s;
      mem_addr_r[wr_ptr_r]  <= addr_r;
    end
  end

  // Pointers, occupancy, address counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r    <= AW'(0);
      rd_ptr_r    <= AW'(0);
      count_r     <= CW'(0);
      addr_r      <= BASE_ADDR;
      out_valid   <= 1'b0;
      out_instr   <= 32'h0000_0000;
      out_addr    <= 32'h0000_0000;
      err_illegal <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= AW'(0);
      rd_ptr_r    <= AW'(0);
      count_r     <= CW'(0);
      addr_r      <= BASE_ADDR;
      out_valid   <= 1'b0;
      out_instr   <= 32'h0000_0000;
      out_addr    <= 32'h0000_0000;
      err_illegal <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
        addr_r   <= addr_r + 32'd4;
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      out_valid   <= (count_nxt_s != CW'(0));
      out_instr   <= head_instr_nxt_s;
      out_addr    <= head_addr_nxt_s;
      err_illegal <= accept_s && (in_kind == 3'd7);
    end
  end

`ifdef INSTR_ENCODER_STATS_EN
  // Saturating count of enqueued words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_count <= 16'h0000;
    end else if (flush) begin
      enc_count <= 16'h0000;
    end else if (push_s && (enc_count != 16'hFFFF)) begin
      enc_count <= enc_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, err_illegal;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [11:0] in_immed;
  logic [9:0]  in_func;
  logic [19:0] in_joffset;
  logic [31:0] out_instr, out_addr;
  logic        w_in_ready, w_out_valid, w_err_illegal;
  logic [31:0] w_out_instr, w_out_addr;
`ifdef INSTR_ENCODER_STATS_EN
  logic [15:0] enc_count, w_enc_count;
`endif

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_immed(in_immed),
    .in_func(in_func), .in_joffset(in_joffset), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
`ifdef INSTR_ENCODER_STATS_EN
    .enc_count(enc_count),
`endif
    .err_illegal(err_illegal)
  );

  // Second instance sees identical traffic but starts near the top of the address space.
  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(WRAP_BASE)) u_wrap (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_immed(in_immed),
    .in_func(in_func), .in_joffset(in_joffset), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_instr(w_out_instr), .out_addr(w_out_addr),
`ifdef INSTR_ENCODER_STATS_EN
    .enc_count(w_enc_count),
`endif
    .err_illegal(w_err_illegal)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] q[$];
  logic [31:0] m_addr = 32'h0;
  int          m_cnt = 0;
  logic        last_acc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoding built from field positions with shifts and masks.
  function automatic logic [31:0] model_enc(input int kind, input logic [31:0] rd, input logic [31:0] rs1,
                                            input logic [31:0] rs2, input logic [31:0] imm,
                                            input logic [31:0] func, input logic [31:0] jo);
    logic [31:0] f3, f7, base;
    f3 = func & 32'd7;
    f7 = func >> 3;
    base = (rs1 << 15) | (f3 << 12);
    case (kind)
      0: return (f7 << 25) | (rs2 << 20) | base | (rd << 7) | 32'h33;
      1: return (imm << 20) | base | (rd << 7) | 32'h13;
      5: return (imm << 20) | base | (rd << 7) | 32'h03;
      2: return ((imm >> 5) << 25) | (rs2 << 20) | base | ((imm & 32'd31) << 7) | 32'h23;
      3: return (((imm >> 11) & 32'd1) << 31) | (((imm >> 4) & 32'd63) << 25) | (rs2 << 20) | base
                | ((imm & 32'd15) << 8) | (((imm >> 10) & 32'd1) << 7) | 32'h63;
      4: return (((jo >> 19) & 32'd1) << 31) | ((jo & 32'd1023) << 21) | (((jo >> 10) & 32'd1) << 20)
                | (((jo >> 11) & 32'd255) << 12) | (rd << 7) | 32'h6F;
      6: return (jo << 12) | (rd << 7) | 32'h17;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    q.delete();
    m_addr = 32'h0;
    m_cnt  = 0;
  endtask

  // One clock: inputs already driven at the falling edge; checks pre-edge ready and post-edge outputs.
  task automatic cycle();
    logic exp_rdy, acc, pop, ill;
    logic [63:0] dummy;
    #1;
    exp_rdy = !flush && (q.size() < DEPTH);
    check_val("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    acc = in_valid && exp_rdy;
    pop = (q.size() > 0) && out_ready;
    ill = 1'b0;
    last_acc = acc;
    if (flush) begin
      model_clear();
    end else begin
      if (pop) dummy = q.pop_front();
      if (acc) begin
        if (in_kind == 3'd7) ill = 1'b1;
        else begin
          q.push_back({model_enc(int'(in_kind), 32'(in_rd), 32'(in_rs1), 32'(in_rs2), 32'(in_immed),
                                 32'(in_func), 32'(in_joffset)), m_addr});
          m_addr = m_addr + 32'd4;
          if (m_cnt < 65535) m_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    check_val("out_valid", {31'b0, out_valid}, {31'b0, (q.size() > 0)});
    check_val("wrap_valid", {31'b0, w_out_valid}, {31'b0, (q.size() > 0)});
    check_val("err_illegal", {31'b0, err_illegal}, {31'b0, ill});
    if (q.size() > 0) begin
      check_val("out_instr", out_instr, q[0][63:32]);
      check_val("out_addr", out_addr, q[0][31:0]);
      check_val("wrap_addr", w_out_addr, q[0][31:0] + WRAP_BASE);
    end
`ifdef INSTR_ENCODER_STATS_EN
    check_val("enc_count", {16'b0, enc_count}, 32'(m_cnt));
`endif
    @(negedge clk);
  endtask

  task automatic set_bundle(input int kind, input int rd, input int rs1, input int rs2,
                            input int imm, input int func, input int jo);
    in_kind = 3'(kind); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_immed = 12'(imm); in_func = 10'(func); in_joffset = 20'(jo);
  endtask

  task automatic send(input int kind, input int rd, input int rs1, input int rs2,
                      input int imm, input int func, input int jo);
    int budget;
    set_bundle(kind, rd, rs1, rs2, imm, func, jo);
    in_valid = 1'b1;
    budget = 20;
    last_acc = 1'b0;
    while (!last_acc && budget > 0) begin
      cycle();
      budget--;
    end
    if (!last_acc) check_val("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    out_ready = rdy;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_bundle(0, 0, 0, 0, 0, 0, 0);
    #12;
    check_val("rst_valid", {31'b0, out_valid}, 32'd0);
    check_val("rst_instr", out_instr, 32'h0);
    check_val("rst_addr", out_addr, 32'h0);
    check_val("rst_err", {31'b0, err_illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();

    // Single I-type word, visible one cycle after accept.
    send(1, 1, 0, 0, 5, 0, 0);
    check_val("i_word", out_instr, 32'h0050_0093);
    check_val("i_addr", out_addr, 32'h0);
    idle(2, 1'b1);

    do_flush();
    out_ready = 1'b0;
    send(0, 3, 1, 2, 0, 0, 0);
    send(3, 0, 1, 2, 12'h004, 0, 0);
    check_val("r_word", out_instr, 32'h0020_81B3);
    idle(1, 1'b1);
    check_val("b_word", out_instr, 32'h0020_8463);
    check_val("b_addr", out_addr, 32'h4);
    idle(2, 1'b1);

    do_flush();
    out_ready = 1'b0;
    send(4, 1, 0, 0, 0, 0, 20'h00004);
    send(6, 5, 0, 0, 0, 0, 20'h12345);
    check_val("j_word", out_instr, 32'h0080_00EF);
    idle(1, 1'b1);
    check_val("auipc_word", out_instr, 32'h1234_5297);
    idle(2, 1'b1);

    // Fill to DEPTH with the consumer stalled; the fifth bundle waits for space.
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1, i + 1, i, 0, i * 3, 0, 0);
    set_bundle(0, 9, 8, 7, 0, 10'h100, 0);
    in_valid = 1'b1;
    idle(3, 1'b0);
    out_ready = 1'b1;
    send(0, 9, 8, 7, 0, 10'h100, 0);
    idle(6, 1'b1);

    // Illegal bundle between two legal ones.
    do_flush();
    out_ready = 1'b0;
    send(2, 0, 4, 5, 12'hABC, 3'd2, 0);
    send(7, 1, 2, 3, 4, 5, 6);
    send(5, 6, 7, 0, 12'h010, 3'd2, 0);
    idle(1, 1'b0);
    check_val("ill_addr0", out_addr, 32'h0);
`ifdef INSTR_ENCODER_STATS_EN
    check_val("ill_count", {16'b0, enc_count}, 32'd2);
`endif
    idle(1, 1'b1);
    check_val("ill_addr1", out_addr, 32'h4);
    idle(2, 1'b1);

    // Flush with three words queued, then restart at base.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(6, i, 0, 0, 0, 0, i * 7);
    do_flush();
    check_val("flush_valid", {31'b0, out_valid}, 32'd0);
    send(1, 2, 3, 0, 1, 0, 0);
    check_val("flush_addr", out_addr, 32'h0);

    // Asynchronous reset mid-stream.
    send(4, 3, 0, 0, 0, 0, 20'hFFFFF);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_valid", {31'b0, out_valid}, 32'd0);
    check_val("arst_instr", out_instr, 32'h0);
    check_val("arst_addr", out_addr, 32'h0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      set_bundle($urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      cycle();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    idle(6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
